alu_serial: RTL and testbench
=============================

ALU_SERIAL -- requirements
Module: alu_serial

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits; also the number of RUN cycles.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  asynchronous, active-low reset.
REQ-004 start_i  input  1  operation request; sampled only in IDLE.
REQ-005 src1_i  input  WIDTH  operand A; latched on accepted start.
REQ-006 src2_i  input  WIDTH  operand B; latched on accepted start.
REQ-007 ALU_control_i  input  4  operation code; latched on accepted start.
REQ-008 busy_o  output  1  high in RUN and DONE.
REQ-009 done_o  output  1  one-cycle pulse when results are valid.
REQ-010 result_o  output  WIDTH  final result; held until the next accepted start.
REQ-011 zero_o  output  1  (result_o == 0).
REQ-012 cout_o  output  1  carry out of the MSB slice.
REQ-013 overflow_o  output  1  signed overflow flag.

Function
REQ-014 Block SHALL be a bit-serial ALU that drives one ALU_1bit slice per cycle, LSB first, with the carry registered between cycles.
REQ-015 Operation codes SHALL be:
- 0000 AND
- 0001 OR
- 0010 ADD
- 0110 SUB
- 1100 NOR
- 0111 SLT
REQ-016 Slice inputs SHALL be Ainvert=ctrl[3] and Binvert=ctrl[2]; slice operation=ctrl[1:0], except SLT, which drives operation=2 (add).
REQ-017 Carry into bit 0 SHALL equal ctrl[2]; carry into bit k>0 SHALL be the registered cout of bit k-1.
REQ-018 FSM SHALL have states IDLE, RUN and DONE.
- IDLE -> RUN: on start_i=1; latch operands and control, clear the bit counter.
- RUN: process one bit per cycle; RUN -> DONE after bit WIDTH-1.
- DONE -> IDLE: unconditionally after one cycle.
REQ-019 start_i SHALL be ignored while busy_o=1; there is no queueing.
REQ-020 done_o SHALL assert WIDTH+1 cycles after the edge that accepts start (33 cycles for WIDTH=32), for exactly one cycle.
REQ-021 result_o, zero_o, cout_o and overflow_o SHALL update only at the RUN->DONE edge, so they are stable while done_o=1 and afterwards.
REQ-022 overflow_o SHALL equal (carry into MSB) XOR (carry out of MSB) for ADD, SUB and SLT, and 0 for all other codes.
REQ-023 For SLT, result_o SHALL be {WIDTH-1 zeros, sum[MSB] XOR overflow}; the subtraction sum itself is not output.
REQ-024 For AND, OR and NOR, cout_o SHALL be the raw slice cout; this value is don't-care for verification.
REQ-025 Undefined control codes SHALL give result_o=0, cout_o=0, overflow_o=0, zero_o=1 after normal latency.
REQ-026 start_i high in the DONE cycle SHALL be ignored; a new start is accepted only in IDLE.

Reset
REQ-027 rst_i=0 SHALL immediately force:
- state IDLE, counter 0, carry register 0;
- busy_o=0, done_o=0;
- result_o=0, zero_o=0, cout_o=0, overflow_o=0.
REQ-028 Reset during RUN or DONE SHALL abort the operation with no done_o pulse.
REQ-029 The first start after reset release SHALL be accepted on the next rising edge with start_i=1.

Structure
REQ-030 Operation codes and FSM state encodings SHALL be defined in the shared package alu_pkg.
REQ-031 The single sub-module SHALL be the existing ALU_1bit, instantiated once; the sequencer, shift register and counter live in alu_serial.
REQ-032 The bit counter SHALL be $clog2(WIDTH) bits wide; no other arithmetic on data bits outside the slice is permitted except the SLT fix-up.

Verification
REQ-033 ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow 1, cout 0, zero 0, done 33 cycles after start.
REQ-034 SUB 0x00000005 - 0x00000005 -> result 0, zero 1, cout 1, overflow 0.
REQ-035 SLT 0xFFFFFFFF vs 0x00000001 -> result 1; SLT 0x80000000 vs 0x7FFFFFFF -> result 1 (overflow path).
REQ-036 AND/OR/NOR on 0xF0F0F0F0, 0x0FF00FF0 -> 0x00F000F0 / 0xFFF0FFF0 / 0x000F000F.
REQ-037 start pulsed at cycle 10 of RUN -> ignored; exactly one done_o, and the first operation's result is unchanged.
REQ-038 rst_i low at bit 15 -> all outputs 0, no done_o; a following ADD 3+4 -> result 7.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: operation codes, FSM states
// and small decode helpers used by the sequencer.
package alu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_NOR = 4'b1100;
   localparam logic [3:0] OP_SLT = 4'b0111;

   function automatic logic op_valid(input logic [3:0] ctrl);
      return (ctrl == OP_AND) || (ctrl == OP_OR)  || (ctrl == OP_ADD) ||
             (ctrl == OP_SUB) || (ctrl == OP_NOR) || (ctrl == OP_SLT);
   endfunction

   // Codes whose signed overflow flag is meaningful.
   function automatic logic op_arith(input logic [3:0] ctrl);
      return (ctrl == OP_ADD) || (ctrl == OP_SUB) || (ctrl == OP_SLT);
   endfunction

endpackage

// File: rtl/alu_serial_alu_1bit.sv
// One ALU bit slice: optional operand inversion, then AND / OR / full-add /
// pass-through of the less input, selected by operation.
module ALU_1bit (
   input  logic       src1_i,
   input  logic       src2_i,
   input  logic       less_i,
   input  logic       Ainvert_i,
   input  logic       Binvert_i,
   input  logic       cin_i,
   input  logic [1:0] operation_i,
   output logic       result_o,
   output logic       cout_o
);

   logic w_a;
   logic w_b;

   assign w_a    = src1_i ^ Ainvert_i;
   assign w_b    = src2_i ^ Binvert_i;
   assign cout_o = (w_a & w_b) | (w_a & cin_i) | (w_b & cin_i);

   always_comb begin
      result_o = 1'b0;
      case (operation_i)
         2'b00:   result_o = w_a & w_b;
         2'b01:   result_o = w_a | w_b;
         2'b10:   result_o = w_a ^ w_b ^ cin_i;
         default: result_o = less_i;
      endcase
   end

endmodule

// File: rtl/alu_serial.sv
// Bit-serial ALU: one ALU_1bit slice is reused WIDTH times, LSB first, with
// the carry held in a register between cycles. Flags are committed at the end.
module alu_serial
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   input  logic [3:0]       ALU_control_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o,
   output logic             cout_o,
   output logic             overflow_o
);

   localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic             r_carry;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [3:0]       r_ctrl;
   logic [WIDTH-1:0] r_acc;

   logic             w_cin;
   logic [1:0]       w_op;
   logic             w_res;
   logic             w_cout;
   logic             w_ovf;
   logic [WIDTH-1:0] w_shifted;
   logic [WIDTH-1:0] w_final;

   assign w_cin     = (r_cnt == '0) ? r_ctrl[2] : r_carry;
   assign w_op      = (r_ctrl == OP_SLT) ? 2'b10 : r_ctrl[1:0];
   assign w_shifted = {w_res, r_acc[WIDTH-1:1]};
   // Only meaningful on the MSB cycle, where w_cin is the carry into the MSB.
   assign w_ovf     = op_arith(r_ctrl) ? (w_cin ^ w_cout) : 1'b0;

   ALU_1bit u_slice (
      .src1_i      (r_a[0]),
      .src2_i      (r_b[0]),
      .less_i      (1'b0),
      .Ainvert_i   (r_ctrl[3]),
      .Binvert_i   (r_ctrl[2]),
      .cin_i       (w_cin),
      .operation_i (w_op),
      .result_o    (w_res),
      .cout_o      (w_cout)
   );

   always_comb begin
      w_final = '0;
      if (r_ctrl == OP_SLT)
         w_final = {{(WIDTH-1){1'b0}}, w_res ^ w_ovf};
      else if (op_valid(r_ctrl))
         w_final = w_shifted;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_carry    <= 1'b0;
         r_a        <= '0;
         r_b        <= '0;
         r_ctrl     <= '0;
         r_acc      <= '0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         result_o   <= '0;
         zero_o     <= 1'b0;
         cout_o     <= 1'b0;
         overflow_o <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start_i) begin
                  r_a     <= src1_i;
                  r_b     <= src2_i;
                  r_ctrl  <= ALU_control_i;
                  r_cnt   <= '0;
                  r_carry <= 1'b0;
                  busy_o  <= 1'b1;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_a     <= r_a >> 1;
               r_b     <= r_b >> 1;
               r_acc   <= w_shifted;
               r_carry <= w_cout;
               r_cnt   <= r_cnt + CW'(1);
               if (r_cnt == LAST_BIT) begin
                  result_o   <= w_final;
                  zero_o     <= (w_final == '0);
                  cout_o     <= op_valid(r_ctrl) ? w_cout : 1'b0;
                  overflow_o <= w_ovf;
                  r_state    <= ST_DONE;
               end
            end
            ST_DONE: begin
               busy_o  <= 1'b0;
               done_o  <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: begin
               busy_o  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_serial.sv
// Directed bench for alu_serial: driver tasks push expected results into a
// queue, an independent monitor pops and compares on every done_o pulse.
module tb_alu_serial;

   localparam int W = 32;

   localparam logic [3:0] C_AND = 4'b0000;
   localparam logic [3:0] C_OR  = 4'b0001;
   localparam logic [3:0] C_ADD = 4'b0010;
   localparam logic [3:0] C_SUB = 4'b0110;
   localparam logic [3:0] C_NOR = 4'b1100;
   localparam logic [3:0] C_SLT = 4'b0111;
   localparam logic [3:0] C_BAD = 4'b0011;

   logic         clk = 1'b0;
   logic         rst_i = 1'b0;
   logic         start_i = 1'b0;
   logic [W-1:0] src1_i = '0;
   logic [W-1:0] src2_i = '0;
   logic [3:0]   ALU_control_i = '0;
   logic         busy_o;
   logic         done_o;
   logic [W-1:0] result_o;
   logic         zero_o;
   logic         cout_o;
   logic         overflow_o;

   alu_serial #(.WIDTH(W)) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .start_i       (start_i),
      .src1_i        (src1_i),
      .src2_i        (src2_i),
      .ALU_control_i (ALU_control_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .result_o      (result_o),
      .zero_o        (zero_o),
      .cout_o        (cout_o),
      .overflow_o    (overflow_o)
   );

   // Clock / cycle counter
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct packed {
      logic [W-1:0] res;
      logic         z;
      logic         c;
      logic         v;
      logic         chk_c;
      logic [31:0]  acc;
   } exp_t;

   exp_t exp_q[$];
   exp_t e_mon;
   int   checks = 0;
   int   failures = 0;
   int   done_seen = 0;
   int   n_exp = 0;
   logic prev_done = 1'b0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (done_o === 1'b1) begin
         done_seen++;
         chk("done_one_cycle", W'(prev_done), W'(0));
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=pulse required=none at cycle %0d", cyc);
         end else begin
            e_mon = exp_q.pop_front();
            chk("result", result_o, e_mon.res);
            chk("zero", W'(zero_o), W'(e_mon.z));
            chk("overflow", W'(overflow_o), W'(e_mon.v));
            if (e_mon.chk_c)
               chk("cout", W'(cout_o), W'(e_mon.c));
            chk("latency", W'(cyc - int'(e_mon.acc)), W'(33));
         end
      end
      prev_done = done_o;
   end

   // Driver tasks
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] c, output int acc);
      @(negedge clk);
      start_i       = 1'b1;
      src1_i        = a;
      src2_i        = b;
      ALU_control_i = c;
      @(posedge clk);
      #1;
      acc           = cyc;
      start_i       = 1'b0;
      src1_i        = $urandom;
      src2_i        = $urandom;
      ALU_control_i = 4'($urandom_range(0, 15));
   endtask

   task automatic push_exp(input logic [W-1:0] res, input logic z, input logic c,
                           input logic v, input logic chk_c, input int acc);
      exp_t e;
      e.res = res; e.z = z; e.c = c; e.v = v; e.chk_c = chk_c; e.acc = 32'(acc);
      exp_q.push_back(e);
      n_exp++;
   endtask

   task automatic wait_done(input string name);
      int n;
      for (n = 0; n < 60; n++) begin
         @(negedge clk);
         if (done_o === 1'b1) break;
      end
      checks++;
      if (n >= 60) begin
         failures++;
         $display("FAIL %s_timeout actual=no_done required=done within 60 cycles", name);
      end
   endtask

   task automatic op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [3:0] c, input logic [W-1:0] res, input logic z,
                     input logic cf, input logic v, input logic chk_c);
      int acc;
      issue(a, b, c, acc);
      push_exp(res, z, cf, v, chk_c, acc);
      wait_done(name);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},     W'(busy_o), W'(0));
      chk({tag, "_done"},     W'(done_o), W'(0));
      chk({tag, "_result"},   result_o,   W'(0));
      chk({tag, "_zero"},     W'(zero_o), W'(0));
      chk({tag, "_cout"},     W'(cout_o), W'(0));
      chk({tag, "_overflow"}, W'(overflow_o), W'(0));
   endtask

   initial begin
      int acc;
      int n;
      rst_i = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_i = 1'b1;

      op("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, C_ADD, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1);
      op("sub_eq",   32'h0000_0005, 32'h0000_0005, C_SUB, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1);
      op("slt_neg",  32'hFFFF_FFFF, 32'h0000_0001, C_SLT, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 1'b1);
      op("slt_ovf",  32'h8000_0000, 32'h7FFF_FFFF, C_SLT, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 1'b1);
      op("slt_ge",   32'h0000_0007, 32'h0000_0003, C_SLT, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1);
      op("and",      32'hF0F0_F0F0, 32'h0FF0_0FF0, C_AND, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0, 1'b0);
      op("or",       32'hF0F0_F0F0, 32'h0FF0_0FF0, C_OR,  32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0, 1'b0);
      op("nor",      32'hF0F0_F0F0, 32'h0FF0_0FF0, C_NOR, 32'h000F_000F, 1'b0, 1'b0, 1'b0, 1'b0);
      op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, C_ADD, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1);
      op("sub_neg",  32'h0000_0000, 32'h0000_0001, C_SUB, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
      op("bad_code", 32'h1234_5678, 32'h9ABC_DEF0, C_BAD, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);

      // start while busy (RUN cycle 10) and in the DONE cycle must be ignored
      issue(32'h0000_0001, 32'h0000_0002, C_ADD, acc);
      push_exp(32'h0000_0003, 1'b0, 1'b0, 1'b0, 1'b1, acc);
      repeat (10) @(negedge clk);
      start_i = 1'b1; src1_i = '0; src2_i = '0; ALU_control_i = C_AND;
      @(negedge clk);
      start_i = 1'b0;
      chk("busy_in_run", W'(busy_o), W'(1));
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (cyc < acc + 32 && n < 40);
      start_i = 1'b1; ALU_control_i = C_OR; src1_i = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      wait_done("busy_start");
      repeat (5) @(negedge clk);
      chk("idle_after_done_start", W'(busy_o), W'(0));

      // reset in the middle of RUN aborts without done
      issue(32'h0000_0010, 32'h0000_0020, C_ADD, acc);
      repeat (16) @(negedge clk);
      rst_i = 1'b0;
      #1;
      chk_all_zero("abort");
      repeat (2) @(negedge clk);
      rst_i = 1'b1;
      repeat (40) @(negedge clk);
      chk("abort_busy", W'(busy_o), W'(0));
      op("add_after_rst", 32'h0000_0003, 32'h0000_0004, C_ADD, 32'h0000_0007, 1'b0, 1'b0, 1'b0, 1'b1);

      repeat (3) @(negedge clk);
      chk("queue_empty", W'(exp_q.size()), W'(0));
      chk("done_count", W'(done_seen), W'(n_exp));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
